// File: rtl/aes_sbox_responder.sv
// aes_sbox_responder
// Responder side of the AES byte-substitution handshake. It captures an
// 8-bit S-box address under a four-phase valid/ack protocol and returns the
// substituted byte after LATENCY cycles. It also keeps a saturating count of
// completed lookups.
// Optional build macro: AES_SBOX_INV_EN adds the rqst_inv input and the
// inverse S-box table. Without it only the forward table exists.

module aes_sbox_responder #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rqst_valid,
  input  logic [7:0]       rqst_addr,
`ifdef AES_SBOX_INV_EN
  input  logic             rqst_inv,
`endif
  output logic             addr_ack,
  output logic             resp_valid,
  output logic [7:0]       resp_data,
  input  logic             data_ack,
  output logic             busy,
  output logic [CNT_W-1:0] lookup_count
);

  // A latency outside 1..4 cannot be represented by the 2-bit countdown.
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("aes_sbox_responder: LATENCY must be in 1..4");
  end

  localparam logic [1:0] LAT_LOAD = 2'(LATENCY - 1);

  // Forward AES S-box (FIPS-197).
  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_SBOX_INV_EN
  // Inverse AES S-box (FIPS-197).
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESPOND,
    RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [1:0]       lat_cnt_q, lat_cnt_d;
  logic             addr_ack_q, addr_ack_d;
  logic             resp_valid_q, resp_valid_d;
  logic [7:0]       resp_data_q, resp_data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       lookup_byte;

`ifdef AES_SBOX_INV_EN
  logic inv_q, inv_d;

  // The table is selected by the direction flag captured with the address.
  assign lookup_byte = inv_q ? INV_SBOX[addr_q] : FWD_SBOX[addr_q];
`else
  assign lookup_byte = FWD_SBOX[addr_q];
`endif

  // State register and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 8'h00;
      lat_cnt_q    <= 2'd0;
      addr_ack_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
      count_q      <= '0;
`ifdef AES_SBOX_INV_EN
      inv_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lat_cnt_q    <= lat_cnt_d;
      addr_ack_q   <= addr_ack_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      count_q      <= count_d;
`ifdef AES_SBOX_INV_EN
      inv_q        <= inv_d;
`endif
    end
  end

  // Next-state and next-output logic of the capture/lookup/respond/release cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lat_cnt_d    = lat_cnt_q;
    addr_ack_d   = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    count_d      = count_q;
`ifdef AES_SBOX_INV_EN
    inv_d        = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (rqst_valid) begin
          addr_d     = rqst_addr;
`ifdef AES_SBOX_INV_EN
          inv_d      = rqst_inv;
`endif
          addr_ack_d = 1'b1;
          lat_cnt_d  = LAT_LOAD;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lat_cnt_q == 2'd0) begin
          resp_data_d  = lookup_byte;
          resp_valid_d = 1'b1;
          state_d      = RESPOND;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      RESPOND: begin
        if (data_ack) begin
          resp_valid_d = 1'b0;
          if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
          end
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!rqst_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_ack     = addr_ack_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign busy         = (state_q != IDLE);
  assign lookup_count = count_q;

endmodule
